// File: rtl/countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the countdown timer: FSM state
//               encoding, register address map, MODE values and CTRL bit
//               positions, plus a small MODE decode helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

  // FSM state encoding (values are architecturally visible in debug views)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  // Register address map
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // MODE field values; 2 and 3 decode as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_BITS     = 4;

  // CTRL register image, packed so that bit 0 is EN and bit 3 is IM
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Only the exact RELOAD encoding repeats; every other MODE is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_if
// Description : Peripheral register bus for the countdown timer.
// Signals     : we    - write strobe, sampled on the rising clock edge
//               addr  - register select (CTRL / PRESET / COUNT / reserved)
//               wdata - write data, WIDTH bits
//               rdata - combinational read data, WIDTH bits
//               irq   - interrupt request from the timer
// Modports    : master - bus owner (processor side / testbench)
//               slave  - the timer peripheral
// Revision    : 1.0  initial release
// ============================================================================
interface countdown_timer_if #(
  parameter int WIDTH = 32
);

  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );

endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Programmable down-counting timer with a memory-mapped
//               register file and an interrupt output. Software loads PRESET
//               and sets CTRL.EN; the timer loads COUNT from PRESET, counts
//               down to zero and raises irq_flag. In auto-reload mode the
//               cycle repeats, giving a periodic one-cycle interrupt pulse.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - register bus (slave modport): we, addr, wdata,
//                       rdata, irq
// Parameters  : WIDTH - width of PRESET, COUNT and the data bus (>= 4); must
//                       match the WIDTH of the connected interface instance
// Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire                 clk,
  input wire                 rst_n,
  countdown_timer_if.slave   bus
);

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  // --------------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------------
  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_irq_flag;

  // --------------------------------------------------------------------------
  // FSM next-state results and side-effect requests
  // --------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_flag_set;     // count reached zero this cycle
  logic             w_flag_hw_clr;  // auto-reload acknowledges its own pulse
  logic             w_en_hw_clr;    // one-shot disarms itself

  // --------------------------------------------------------------------------
  // Bus write decode
  // --------------------------------------------------------------------------
  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic             w_sw_clr;
  logic [WIDTH-1:0] w_rdata;

  assign w_wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign w_wr_preset = bus.we && (bus.addr == ADDR_PRESET);
  // Any write to a writable register acknowledges the interrupt.
  assign w_sw_clr    = w_wr_ctrl || w_wr_preset;

  // --------------------------------------------------------------------------
  // FSM: state and COUNT registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= c_zero;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state and COUNT update
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_flag_set    = 1'b0;
    w_flag_hw_clr = 1'b0;
    w_en_hw_clr   = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_ctrl.en) begin
          w_state_nxt = LOAD;
        end
      end

      LOAD: begin
        // PRESET is only sampled here, so mid-count PRESET writes wait for
        // the next reload.
        w_count_nxt = r_preset;
        w_state_nxt = CNT;
      end

      CNT: begin
        // EN low pauses the count without leaving CNT, so re-enabling
        // resumes where it stopped instead of reloading.
        if (r_ctrl.en) begin
          // <= 1 rather than == 1 so a PRESET of zero terminates like one
          // and COUNT can never wrap.
          if (r_count <= c_one) begin
            w_count_nxt = c_zero;
            w_flag_set  = 1'b1;
            w_state_nxt = INT;
          end else begin
            w_count_nxt = r_count - c_one;
          end
        end
      end

      INT: begin
        if (is_reload(r_ctrl.mode)) begin
          // EN stays set, so IDLE immediately re-arms the timer.
          w_flag_hw_clr = 1'b1;
        end else begin
          // One-shot keeps irq_flag until software acknowledges it.
          w_en_hw_clr   = 1'b1;
        end
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file and interrupt flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_preset   <= c_zero;
      r_irq_flag <= 1'b0;
    end else begin
      // A software CTRL write overrides the one-shot EN clear on the same
      // edge.
      if (w_wr_ctrl) begin
        r_ctrl.en   <= bus.wdata[CTRL_EN_BIT];
        r_ctrl.mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_ctrl.im   <= bus.wdata[CTRL_IM_BIT];
      end else if (w_en_hw_clr) begin
        r_ctrl.en   <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= bus.wdata;
      end

      // A software acknowledge beats a flag being raised on the same edge.
      if (w_sw_clr) begin
        r_irq_flag <= 1'b0;
      end else if (w_flag_set) begin
        r_irq_flag <= 1'b1;
      end else if (w_flag_hw_clr) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = c_zero;
    case (bus.addr)
      ADDR_CTRL:   w_rdata[CTRL_BITS-1:0] = r_ctrl;
      ADDR_PRESET: w_rdata = r_preset;
      ADDR_COUNT:  w_rdata = r_count;
      default:     w_rdata = c_zero;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign bus.irq   = r_ctrl.im & r_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. Directed scenarios
//               with hand-derived expected values, followed by a randomized
//               soak. Every cycle is also compared against a behavioural
//               reference model of the timer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;
  import timer_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // --------------------------------------------------------------------------
  // Reference model. The timer is described as a sequence of phases:
  // waiting for EN, arming (one cycle), running, and expiring (one cycle).
  // --------------------------------------------------------------------------
  localparam int PH_WAIT = 0, PH_ARM = 1, PH_RUN = 2, PH_EXPIRE = 3;

  int          m_phase;
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;

  task automatic model_reset();
    m_phase  = PH_WAIT;
    m_en     = 1'b0;
    m_im     = 1'b0;
    m_mode   = 2'd0;
    m_flag   = 1'b0;
    m_preset = 32'd0;
    m_count  = 32'd0;
  endtask

  // Advance the model by one rising edge using the bus inputs now applied.
  task automatic model_edge();
    bit          wr_c, wr_p, expired, ack_self, disarm;
    int          ph;
    logic [31:0] cnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr_c = bus.we && (bus.addr == 2'd0);
    wr_p = bus.we && (bus.addr == 2'd1);
    ph = m_phase; cnt = m_count; expired = 0; ack_self = 0; disarm = 0;
    if (m_phase == PH_WAIT) begin
      if (m_en) ph = PH_ARM;
    end else if (m_phase == PH_ARM) begin
      cnt = m_preset; ph = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (m_en) begin
        expired = (m_count < 2);
        cnt     = expired ? 32'd0 : m_count - 32'd1;
        if (expired) ph = PH_EXPIRE;
      end
    end else begin
      ph = PH_WAIT;
      if (m_mode == 2'd1) ack_self = 1; else disarm = 1;
    end
    if (wr_c) {m_im, m_mode, m_en} = bus.wdata[3:0];
    else if (disarm) m_en = 1'b0;
    if (wr_p) m_preset = bus.wdata;
    if (wr_c || wr_p) m_flag = 1'b0;
    else if (expired) m_flag = 1'b1;
    else if (ack_self) m_flag = 1'b0;
    m_phase = ph;
    m_count = cnt;
  endtask

  // --------------------------------------------------------------------------
  // Checking and bus helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    logic [1:0] save;
    save     = bus.addr;
    bus.addr = a;
    #1;
    d        = bus.rdata;
    bus.addr = save;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    rd(2'd0, d); check({tag, "/ctrl"},   d, {28'd0, m_im, m_mode, m_en});
    rd(2'd1, d); check({tag, "/preset"}, d, m_preset);
    rd(2'd2, d); check({tag, "/count"},  d, m_count);
    check({tag, "/irq"}, {31'd0, bus.irq}, {31'd0, m_im & m_flag});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    #3 rst_n = 1'b1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(ADDR_COUNT, d);
    check(tag, d, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  // Watchdog: the bench never waits on DUT events, but guard anyway.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] v;
    logic [31:0] exp_c;
    logic [1:0]  a;
    int          p;

    rst_n = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check("reset_rdata", v, 32'd0);
    end
    chk_irq("reset_irq", 1'b0);
    do_reset();

    // One-shot: PRESET 3, EN+IM
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'b1001);
    step();
    step(); chk_cnt("os_e2", 32'd3);
    step(); chk_cnt("os_e3", 32'd2);
    step(); chk_cnt("os_e4", 32'd1); chk_irq("os_e4_irq", 1'b0);
    step(); chk_cnt("os_e5", 32'd0); chk_irq("os_e5_irq", 1'b1);
    step(); rd(ADDR_CTRL, v); check("os_en_clr", v, 32'b1000); chk_irq("os_e6_irq", 1'b1);
    repeat (3) step();
    chk_irq("os_hold_irq", 1'b1);
    wr(ADDR_CTRL, 32'b1000);
    chk_irq("os_ack_irq", 1'b0);

    // Auto-reload: PRESET 2 -> COUNT 2,1,0,0,0,2,..., irq every 5 cycles
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'b1011);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 2) begin
        exp_c = 32'd0; p = -1;
      end else begin
        p = (k - 2) % 5;
        exp_c = (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
      end
      chk_cnt("ar_count", exp_c);
      chk_irq("ar_irq", p == 2);
    end

    // Pause at 7 then resume, then asynchronous reset mid-count at 5
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'b0001);
    repeat (4) step();
    chk_cnt("pz_e4", 32'd8);
    wr(ADDR_CTRL, 32'b0000);
    chk_cnt("pz_stop", 32'd7);
    repeat (4) begin
      step(); chk_cnt("pz_hold", 32'd7);
    end
    wr(ADDR_CTRL, 32'b0001);
    chk_cnt("pz_reen", 32'd7);
    step(); chk_cnt("pz_resume", 32'd6);
    step(); chk_cnt("pz_five", 32'd5);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    rd(ADDR_COUNT, v);  check("arst_count", v, 32'd0);
    rd(ADDR_CTRL, v);   check("arst_ctrl", v, 32'd0);
    rd(ADDR_PRESET, v); check("arst_preset", v, 32'd0);
    chk_irq("arst_irq", 1'b0);
    step();
    rst_n = 1'b1;
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'b0001);
    step(); step(); chk_cnt("arst_restart", 32'd4);

    // PRESET 0 and PRESET 1 both expire after edge 3
    for (int n = 0; n < 2; n++) begin
      do_reset();
      wr(ADDR_PRESET, 32'(n));
      wr(ADDR_CTRL, 32'b1001);
      step(); chk_irq("p01_e1", 1'b0);
      step(); chk_irq("p01_e2", 1'b0); chk_cnt("p01_e2_cnt", 32'(n));
      step(); chk_irq("p01_e3", 1'b1); chk_cnt("p01_e3_cnt", 32'd0);
    end

    // Maximum PRESET
    do_reset();
    wr(ADDR_PRESET, 32'hFFFF_FFFF);
    wr(ADDR_CTRL, 32'b0001);
    step(); step(); chk_cnt("max_load", 32'hFFFF_FFFF);
    step(); chk_cnt("max_dec", 32'hFFFF_FFFE);
    rd(ADDR_RSVD, v); check("rsvd_read", v, 32'd0);

    // IM = 0 masks the interrupt
    do_reset();
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'b0001);
    repeat (3) step();
    chk_irq("im0_e3", 1'b0);
    step(); chk_irq("im0_e4", 1'b0);

    // PRESET change mid-count and ignored COUNT write (auto-reload, IM 0)
    do_reset();
    wr(ADDR_PRESET, 32'd6);
    wr(ADDR_CTRL, 32'b0011);
    repeat (3) step();
    chk_cnt("mid_e3", 32'd5);
    wr(ADDR_PRESET, 32'd20);
    chk_cnt("mid_e4", 32'd4);
    rd(ADDR_PRESET, v); check("mid_preset", v, 32'd20);
    step();
    wr(ADDR_COUNT, 32'd99);
    chk_cnt("cnt_wr_ign", 32'd2);
    repeat (4) step();
    step(); chk_cnt("mid_reload", 32'd20);

    // CTRL write on the INT edge; PRESET write on the flag-set edge
    do_reset();
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'b1001);
    repeat (3) step();
    step(); chk_irq("col_e4", 1'b1);
    wr(ADDR_CTRL, 32'b1101);
    rd(ADDR_CTRL, v); check("col_ctrl_wins", v, 32'b1101);
    chk_irq("col_flag_clr", 1'b0);
    step(); step(); step();
    wr(ADDR_PRESET, 32'd2);
    chk_irq("col_set_vs_clr", 1'b0);
    chk_cnt("col_cnt0", 32'd0);
    step();
    rd(ADDR_CTRL, v); check("mode2_oneshot", v, 32'b1100);

    // Randomized soak against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        a = 2'($urandom_range(0, 3));
        if (a == ADDR_CTRL) begin
          v = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) != 0) v[0] = 1'b1;
        end else if (a == ADDR_PRESET) begin
          v = 32'($urandom_range(0, 7));
        end else begin
          v = $urandom;
        end
        wr(a, v);
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer with a small register interface and interrupt output. Software writes a preset value and control word, then the block counts down to zero and raises an interrupt. In auto-reload mode it repeats, giving a periodic tick. It is the down-counting, event-generating companion to the free-running up-counter and sits on the processor's peripheral bus as a memory-mapped device.

## Interface
- `WIDTH`, default 32: width of the PRESET and COUNT registers, and of the data bus.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `we`, input, 1: register write strobe, sampled on the rising edge of `clk`.
- `addr`, input, 2: register select. 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved.
- `wdata`, input, WIDTH: write data.
- `rdata`, output, WIDTH: combinational read of the register selected by `addr`.
- `irq`, output, 1: interrupt, equal to `CTRL.IM & irq_flag`.

## Operation
- **CTRL register:** bit0 EN, bits[2:1] MODE, bit3 IM; all other bits read as 0.
  - MODE 0 = one-shot; MODE 1 = auto-reload; MODE 2 and 3 behave as MODE 0.
- **Reads:** `addr` 0 returns `{0, IM, MODE, EN}`, 1 returns PRESET, 2 returns COUNT, 3 returns 0.
- **Writes:**
  - A write to CTRL or PRESET updates the register at the clock edge.
  - A write to CTRL or PRESET also clears `irq_flag`.
  - Writes to `addr` 2 or 3 are ignored.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN = 1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT, EN = 0: hold COUNT and stay in CNT (pause).
  - CNT, EN = 1 and COUNT <= 1: COUNT <= 0, set `irq_flag`, go to INT.
  - CNT, EN = 1 and COUNT > 1: COUNT <= COUNT - 1.
  - INT, MODE 0: hardware clears EN, go to IDLE; `irq_flag` stays set until software clears it.
  - INT, MODE 1: clear `irq_flag`, go to IDLE; EN remains 1, so the timer reloads.
- **Arithmetic:** unsigned; COUNT never wraps below 0. PRESET = 0 behaves identically to PRESET = 1.
- **Changing PRESET mid-count:** no effect on COUNT until the next LOAD.
- **Simultaneous events:**
  - A software CTRL write in the same cycle as the hardware EN-clear in INT: the software value wins.
  - A software write in the same cycle as `irq_flag` being set: the clear wins.
- **Reset** (asynchronous, any state): state = IDLE; CTRL, PRESET, COUNT and `irq_flag` = 0; therefore `irq` = 0 and `rdata` reads 0 for every address.

## Timing
- Edge 0 is the edge that writes CTRL.EN = 1 with PRESET = N already loaded.
  - Edge 1: state = LOAD.
  - Edge 2: COUNT = N, state = CNT.
  - Edge 2+k: COUNT = N - k, for N - k >= 1.
  - Edge N+2: COUNT = 0, state = INT, `irq_flag` = 1.
- **Latency:** `irq` is visible after edge N+2, i.e. N+2 cycles, for N >= 1.
- **MODE 1 period:** INT (edge N+2), IDLE (N+3), LOAD (N+4), COUNT = N at N+5. The period is N+3 cycles and `irq` is a 1-cycle pulse.
- **MODE 0:** `irq` stays high from edge N+2 until the edge of the clearing write; EN reads 0 after edge N+3.
- **Pause:** with EN = 0 in CNT, COUNT freezes. Re-enabling resumes the decrement on the next edge with no reload.
- **`rdata`:** purely combinational from `addr` and the registers; it has zero latency and reflects values updated at the previous edge.

## Structure
- Shared package `timer_pkg` holds:
  - state encoding (IDLE = 0, LOAD = 1, CNT = 2, INT = 3);
  - address constants `ADDR_CTRL`, `ADDR_PRESET`, `ADDR_COUNT`;
  - MODE constants `MODE_ONESHOT`, `MODE_RELOAD`;
  - CTRL bit indices.
- No sub-module: one FSM always block, one register-write block and one combinational read mux.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-count (COUNT = 5) → COUNT, CTRL, PRESET, `irq` all 0 immediately, without waiting for a clock; state IDLE after release.
- **One-shot:** PRESET = 3, CTRL = 0b1001 (EN, MODE 0, IM) → COUNT reads 3, 2, 1, 0 on edges 2 to 5; `irq` rises after edge 5; EN reads 0; `irq` stays 1 until a CTRL write clears it.
- **Auto-reload:** PRESET = 2, CTRL = 0b1011 → `irq` is a 1-cycle pulse every 5 cycles; COUNT sequence is 2, 1, 0, 0, 0, 2, …
- **Pause:** PRESET = 10, count down to 7, write CTRL EN = 0 for 4 cycles → COUNT holds at 7; re-enable → reads 6 on the next edge.
- **Boundary:**
  - PRESET = 0 → `irq` after edge 3, same as PRESET = 1.
  - PRESET = 0xFFFFFFFF loads correctly and decrements to 0xFFFFFFFE.
  - IM = 0 → `irq` stays 0 while `irq_flag` is set.
- **Collisions:**
  - PRESET write mid-count → COUNT is unaffected until the next reload.
  - A write to `addr` 2 is ignored.
  - A CTRL write on the INT edge → the written CTRL value holds and `irq_flag` = 0.
